// File: rtl/clock_divider_pkg.sv
// Shared types and reset defaults for the clock/strobe divider.
// Benches import the same defaults so expectations track the design.
package clock_divider_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } div_mode_t;

    localparam int   DEFAULT_DIV_C = 9;
    localparam logic RESET_LEVEL_C = 1'b1;

endpackage

// File: rtl/rollover_counter.sv
// Free-running 0..terminal counter with a combinational wrap flag.
// i_clear restarts the period from zero regardless of enable.
module rollover_counter
    import clock_divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_terminal,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap
);

    logic [WIDTH-1:0] r_count;

    assign o_wrap  = i_enable && (r_count == i_terminal);
    assign o_count = r_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear || o_wrap) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/clock_divider.sv
// Runtime-programmable clock/strobe divider with a rollover tick.
// Divisor and mode changes only land on a period boundary.
module clock_divider
    import clock_divider_pkg::*;
#(
    parameter int   WIDTH       = 8,
    parameter int   DEFAULT_DIV = DEFAULT_DIV_C,
    parameter logic RESET_LEVEL = RESET_LEVEL_C
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_div,
    input  logic             i_mode,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_load_pending,
    output logic [WIDTH-1:0] o_div_active
);

    logic [WIDTH-1:0] r_div_act;
    logic [WIDTH-1:0] r_div_pend;
    div_mode_t        r_mode_act;
    div_mode_t        r_mode_pend;
    logic             r_pending;
    logic             r_clk;
    logic             r_tick;

    logic [WIDTH-1:0] w_count;
    logic [WIDTH-1:0] w_div_next;
    div_mode_t        w_mode_next;
    logic             w_wrap;
    logic             w_idle_apply;

    // While frozen there is no boundary to wait for, so a pending
    // change lands straight away and restarts the period.
    assign w_idle_apply = !i_enable && r_pending;

    rollover_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_enable   (i_enable),
        .i_clear    (w_idle_apply),
        .i_terminal (r_div_act),
        .o_count    (w_count),
        .o_wrap     (w_wrap)
    );

    always_comb begin
        w_div_next  = r_div_act;
        w_mode_next = r_mode_act;
        if (w_wrap && i_load) begin
            w_div_next  = i_div;
            w_mode_next = div_mode_t'(i_mode);
        end else if ((w_wrap && r_pending) || w_idle_apply) begin
            w_div_next  = r_div_pend;
            w_mode_next = r_mode_pend;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_div_act   <= WIDTH'(DEFAULT_DIV);
            r_mode_act  <= MODE_TOGGLE;
            r_div_pend  <= WIDTH'(DEFAULT_DIV);
            r_mode_pend <= MODE_TOGGLE;
            r_pending   <= 1'b0;
            r_clk       <= RESET_LEVEL;
            r_tick      <= 1'b0;
        end else begin
            r_tick     <= w_wrap;
            r_div_act  <= w_div_next;
            r_mode_act <= w_mode_next;

            if (w_wrap) begin
                r_pending <= 1'b0;
            end else if (i_load) begin
                r_div_pend  <= i_div;
                r_mode_pend <= div_mode_t'(i_mode);
                r_pending   <= 1'b1;
            end else if (w_idle_apply) begin
                r_pending <= 1'b0;
            end

            // The mode in force after this edge decides wrap behaviour.
            if (w_wrap) begin
                r_clk <= (w_mode_next == MODE_PULSE) ? 1'b1 : ~r_clk;
            end else if (i_enable && r_mode_act == MODE_PULSE) begin
                r_clk <= 1'b0;
            end
        end
    end

    assign o_clk          = r_clk;
    assign o_tick         = r_tick;
    assign o_load_pending = r_pending;
    assign o_div_active   = r_div_act;

    logic unused_count;
    assign unused_count = ^w_count;

endmodule
